alu_arbiter: RTL and testbench

Shares one `Alu` instance between `NUM_REQ` independent requesters using round-robin arbitration with an optional lock. Each accepted operation is issued to the ALU in the acceptance cycle. The result and flags return to the issuing requester one cycle later. Sits between the sequencing/issue logic and the `Alu` datapath; the `Alu` ports are driven only by this block.

---
 rtl/alu_arb_pkg.sv | 39 +++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 20 ++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter slice.
//   - opcode constants understood by the Alu datapath
//   - flag bit positions inside the 4-bit flags word {rsvd, zero, carry, ovf}
//   - arbiter state enum and the idle opcode driven when nothing is issued
package alu_arb_pkg;

  localparam logic [3:0] OP_INCA    = 4'h0;
  localparam logic [3:0] OP_DECA    = 4'h1;
  localparam logic [3:0] OP_ADD     = 4'h2;
  localparam logic [3:0] OP_SUB     = 4'h3;
  localparam logic [3:0] OP_ABS     = 4'h4;
  localparam logic [3:0] OP_NEGA    = 4'h5;
  localparam logic [3:0] OP_ILLEGAL = 4'h6;
  localparam logic [3:0] OP_NEGB    = 4'h7;
  localparam logic [3:0] OP_AND     = 4'h8;
  localparam logic [3:0] OP_OR      = 4'h9;
  localparam logic [3:0] OP_XOR     = 4'hA;
  localparam logic [3:0] OP_INVB    = 4'hB;
  localparam logic [3:0] OP_PASSA   = 4'hC;
  localparam logic [3:0] OP_INVA    = 4'hD;
  localparam logic [3:0] OP_ZEROES  = 4'hE;
  localparam logic [3:0] OP_ONES    = 4'hF;

  // ZEROES keeps the Alu output at a known value while idle.
  localparam logic [3:0] OP_IDLE    = OP_ZEROES;

  localparam int FLAG_OVF   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;

  // Flags reported for a trapped illegal opcode: only ZERO set.
  localparam logic [3:0] TRAP_FLAGS = 4'b0100;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bus of the ALU arbiter.
//   req_valid/req_lock/req_inst/req_a/req_b : per-requester op, packed by index
//   req_ready                               : one-hot accept strobe
//   rsp_valid/rsp_z/rsp_flags/rsp_err       : response, one cycle after accept
// Modports: master = requesters, slave = arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_lock;
  logic [4*NUM_REQ-1:0]     req_inst;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_z;
  logic [3:0]               rsp_flags;
  logic                     rsp_err;

  modport master (
    output req_valid, req_lock, req_inst, req_a, req_b,
    input  req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_lock, req_inst, req_a, req_b,
    output req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: round-robin one-hot picker.
//   req : request vector
//   ptr : one-hot priority pointer (highest priority position)
//   gnt : one-hot grant of the first request at or after ptr, wrapping; 0 if none
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_gnt;

  // Doubling the request vector turns the wrap-around search into a plain
  // "lowest set bit at or above ptr" search, done with one subtraction.
  assign dbl     = {req, req};
  assign dbl_gnt = dbl & ~(dbl - {{N{1'b0}}, ptr});
  assign gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one Alu between NUM_REQ requesters, round-robin with lock.
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : requester ops in, one-hot ready, response one cycle later
//   alu_a/b/inst      : combinational issue to the Alu (idle values when no grant)
//   alu_z/alu_flags   : Alu result, valid in the cycle after issue
// Build option: ALU_ARB_OP6_TRAP_EN traps opcode 6 locally instead of issuing it.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_inst,
  input  logic [WIDTH-1:0] alu_z,
  input  logic [3:0]       alu_flags
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [NUM_REQ-1:0] ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [IDX_W-1:0]   gnt_idx;
  logic               accept;
  logic               issue;
  logic               sel_lock;
  logic [3:0]         sel_inst;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  function automatic logic [NUM_REQ-1:0] rotl1(input logic [NUM_REQ-1:0] x);
    return {x[NUM_REQ-2:0], x[NUM_REQ-1]};
  endfunction

  assign owner_oh = NUM_REQ'(1) << owner;

  // Ready is a function of valid, state and ptr only; in LOCKED the picker
  // only ever sees the owner. Held at zero during reset.
  assign pick_req = ((state == LOCKED) ? (bus.req_valid & owner_oh) : bus.req_valid)
                    & {NUM_REQ{rst_n}};

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign sel_lock = bus.req_lock[gnt_idx];
  assign sel_inst = bus.req_inst[4*int'(gnt_idx) +: 4];
  assign sel_a    = bus.req_a[WIDTH*int'(gnt_idx) +: WIDTH];
  assign sel_b    = bus.req_b[WIDTH*int'(gnt_idx) +: WIDTH];

`ifdef ALU_ARB_OP6_TRAP_EN
  assign issue = accept && (sel_inst != OP_ILLEGAL);
`else
  assign issue = accept;
`endif

  assign alu_a    = issue ? sel_a : '0;
  assign alu_b    = issue ? sel_b : '0;
  assign alu_inst = issue ? sel_inst : OP_IDLE;

`ifdef ALU_ARB_OP6_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= accept && (sel_inst == OP_ILLEGAL);
  end

  assign bus.rsp_z     = trap_q ? '0 : alu_z;
  assign bus.rsp_flags = trap_q ? TRAP_FLAGS : alu_flags;
  assign bus.rsp_err   = trap_q & rst_n;
`else
  assign bus.rsp_z     = alu_z;
  assign bus.rsp_flags = alu_flags;
  assign bus.rsp_err   = 1'b0;
`endif

  // Gating with rst_n drops a response that would otherwise show during a
  // reset cycle, so an in-flight result is never reported across reset.
  assign bus.rsp_valid = rsp_valid_q & {NUM_REQ{rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB;
      ptr         <= NUM_REQ'(1);
      owner       <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= gnt;
      case (state)
        ARB: begin
          if (accept) begin
            ptr <= rotl1(gnt);
            if (sel_lock) begin
              state <= LOCKED;
              owner <= gnt_idx;
            end
          end
        end
        LOCKED: begin
          // No accept here means the owner dropped valid.
          if (!accept || !sel_lock) begin
            state <= ARB;
            ptr   <= rotl1(owner_oh);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 3;
  localparam int W = 32;

  typedef struct {
    int         idx;
    logic [W-1:0] z;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_inst;
  logic [W-1:0] alu_z = '0;
  logic [3:0]   alu_flags = '0;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t scb[$];

  // reference model state: next round-robin start and lock owner (-1 = none)
  int m_ptr   = 0;
  int m_owner = -1;

  alu_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_inst  (alu_inst),
    .alu_z     (alu_z),
    .alu_flags (alu_flags)
  );

  always #5 clk = ~clk;

  // Behavioural Alu: {flags, z} from opcode arithmetic.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   w;
    logic [W-1:0] z;
    logic         c, o;
    w = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'h0: begin w = {1'b0, a} + 1; z = w[W-1:0]; c = w[W]; o = !a[W-1] && z[W-1]; end
      4'h1: begin w = {1'b0, a} - 1; z = w[W-1:0]; c = w[W]; o = a[W-1] && !z[W-1]; end
      4'h2: begin w = {1'b0, a} + {1'b0, b}; z = w[W-1:0]; c = w[W];
                  o = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]); end
      4'h3: begin w = {1'b0, a} - {1'b0, b}; z = w[W-1:0]; c = w[W];
                  o = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]); end
      4'h4: z = a[W-1] ? -a : a;
      4'h5: z = -a;
      4'h6: z = a ^ b ^ 32'h0000_6666;
      4'h7: z = -b;
      4'h8: z = a & b;
      4'h9: z = a | b;
      4'hA: z = a ^ b;
      4'hB: z = ~b;
      4'hC: z = a;
      4'hD: z = ~a;
      4'hE: z = '0;
      default: z = '1;
    endcase
    return {1'b0, (z == '0), c, o, z};
  endfunction

  always @(posedge clk) {alu_flags, alu_z} <= alu_fn(alu_inst, alu_a, alu_b);

  function automatic bit trap_op(input logic [3:0] op);
`ifdef ALU_ARB_OP6_TRAP_EN
    return op == 4'h6;
`else
    return (op == 4'hF) && 1'b0;
`endif
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_owner >= 0) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: on each edge, predict the accept and push its response.
  always @(posedge clk) begin
    int g;
    exp_t e;
    if (!rst_n) begin
      m_ptr   = 0;
      m_owner = -1;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        e.idx = g;
        if (trap_op(bus.req_inst[4*g +: 4])) begin
          e.z = '0; e.flags = 4'b0100; e.err = 1'b1;
        end else begin
          {e.flags, e.z} = alu_fn(bus.req_inst[4*g +: 4], bus.req_a[W*g +: W], bus.req_b[W*g +: W]);
          e.err = 1'b0;
        end
        scb.push_back(e);
        m_ptr = (g + 1) % N;
        if (m_owner >= 0) begin
          if (!bus.req_lock[g]) m_owner = -1;
        end else if (bus.req_lock[g]) begin
          m_owner = g;
        end
      end else if (m_owner >= 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // Monitor: grant/issue checks every cycle, responses popped from the scoreboard.
  always @(negedge clk) begin
    int g;
    exp_t e;
    g = model_grant();
    check("req_ready", 64'(bus.req_ready), 64'(onehot(g)));
    if (g >= 0 && !trap_op(bus.req_inst[4*g +: 4])) begin
      check("alu_inst", 64'(alu_inst), 64'(bus.req_inst[4*g +: 4]));
      check("alu_a", 64'(alu_a), 64'(bus.req_a[W*g +: W]));
      check("alu_b", 64'(alu_b), 64'(bus.req_b[W*g +: W]));
    end else begin
      check("alu_inst_idle", 64'(alu_inst), 64'(OP_IDLE));
      check("alu_ab_idle", 64'({alu_a, alu_b}), 64'(0));
    end
    if (!rst_n) begin
      check("rsp_valid_reset", 64'(bus.rsp_valid), 64'(0));
      scb.delete();
    end else if (scb.size() > 0) begin
      e = scb.pop_front();
      check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(e.idx)));
      check("rsp_z", 64'(bus.rsp_z), 64'(e.z));
      check("rsp_flags", 64'(bus.rsp_flags), 64'(e.flags));
      check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
    end else begin
      check("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit l, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]         = v;
    bus.req_lock[i]          = l;
    bus.req_inst[4*i +: 4]   = op;
    bus.req_a[W*i +: W]      = a;
    bus.req_b[W*i +: W]      = b;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    idle_all();
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rsp_z", 64'(bus.rsp_z), 64'(0));

    // Two requesters hold valid: grants alternate starting at req0.
    for (int c = 0; c < 4; c++) begin
      step();
      drive(0, 1'b1, 1'b0, OP_ADD, 32'd5, 32'd7);
      drive(1, 1'b1, 1'b0, OP_SUB, 32'd5, 32'd7);
      #3;
      check("alt_ready", 64'(bus.req_ready), (c % 2 == 0) ? 64'b001 : 64'b010);
    end
    step();
    idle_all();

    // Locked two-op sequence from req0 while req1 keeps requesting.
    k = 0;
    for (int c = 0; c < 12 && k < 2; c++) begin
      step();
      drive(1, 1'b1, 1'b0, OP_ADD, 32'd1, 32'd2);
      if (k == 0) drive(0, 1'b1, 1'b1, OP_ABS, 32'hFFFF_FFF6, 32'd0);
      else        drive(0, 1'b1, 1'b0, OP_ADD, 32'h0000_000A, 32'd1);
      #3;
      if (k == 1) check("lock_hold_r1", 64'(bus.req_ready[1]), 64'(0));
      if (bus.req_ready[0]) k++;
    end
    check("lock_seq_done", 64'(k), 64'(2));
    step();
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    #3;
    check("unlock_r1_ready", 64'(bus.req_ready), 64'b010);
    step();
    idle_all();

    // Wrap: req2 alone, then req0 and req1 -> ptr wrapped to req0.
    step();
    drive(2, 1'b1, 1'b0, OP_XOR, 32'h1234_5678, 32'hFFFF_0000);
    #3;
    check("wrap_r2", 64'(bus.req_ready), 64'b100);
    step();
    idle_all();
    drive(0, 1'b1, 1'b0, OP_INCA, 32'hFFFF_FFFF, 32'd0);
    drive(1, 1'b1, 1'b0, OP_DECA, 32'd0, 32'd0);
    #3;
    check("wrap_r0", 64'(bus.req_ready), 64'b001);
    step();
    idle_all();

    // Opcode 6 from req1.
    step();
    drive(1, 1'b1, 1'b0, 4'h6, 32'hAAAA_0000, 32'h0000_5555);
    #3;
`ifdef ALU_ARB_OP6_TRAP_EN
    check("op6_alu_inst", 64'(alu_inst), 64'hE);
`else
    check("op6_alu_inst", 64'(alu_inst), 64'h6);
`endif
    step();
    idle_all();

    // Reset right after a locking accept.
    step();
    drive(0, 1'b1, 1'b1, OP_PASSA, 32'hCAFE_F00D, 32'd0);
    step();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #3;
    check("post_reset_rsp", 64'(bus.rsp_valid), 64'(0));
    step();
    drive(0, 1'b1, 1'b0, OP_OR, 32'h0F0F_0000, 32'h0000_F0F0);
    drive(1, 1'b1, 1'b0, OP_AND, 32'hFFFF_FFFF, 32'h1234_5678);
    #3;
    check("post_reset_arb", 64'(bus.req_ready), 64'b001);

    // Randomised traffic, including lock sequences, drops and rare resets.
    for (int c = 0; c < 500; c++) begin
      step();
      rst_n = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < N; i++) begin
        drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 9)),
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 9)));
      end
    end
    step();
    rst_n = 1'b1;
    idle_all();
    repeat (3) step();
    check("scoreboard_drained", 64'(scb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
